spi_slave_wishbone: RTL and testbench

- SPI mode-0 target (peripheral) that bridges SPI frames onto a Wishbone master port.
- The other end of our SPI master link: an FPGA register file becomes reachable from an external SPI master, or from our own SPI_MasterWishbone on another board.
- Frame format: byte 0 is the command {R/nW, addr[6:0]}; the following bytes are data with address auto-increment.
- sck, cs and mosi are oversampled in the CLK_I domain; no second clock domain.

---
 rtl/spi_slave_pkg.sv | 20 ++
 rtl/spi_slave_wishbone_sync_edge.sv | 33 +++
 rtl/spi_slave_wishbone.sv | 245 ++++++++++++++++++++++++
 tb/tb_spi_slave_wishbone.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the
// SPI-target to Wishbone-master bridge.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_CMD,
        F_DATA
    } frame_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_WRITE,
        B_READ
    } bus_state_t;

    localparam logic [7:0] BUS_ERR_FILL = 8'hEE;
    localparam int         CMD_RNW_BIT  = 7;

endpackage

// File: rtl/spi_slave_wishbone_sync_edge.sv
// spiSyncEdge: two-flop synchronizer plus an edge register
// for one asynchronous SPI pin.
module spiSyncEdge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    // resynchronize the pin, then keep one older sample for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_wishbone.sv
// spi_slave_wishbone: SPI mode-0 target whose frames become
// Wishbone single cycles (command byte, then data bytes).
module spi_slave_wishbone
    import spi_slave_pkg::*;
#(
    parameter int         ADDR_WIDTH      = 7,
    parameter int         AUTO_INC        = 1,
    parameter logic [7:0] TURNAROUND_FILL = 8'h00
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  sck,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  misoOe,
    output logic [ADDR_WIDTH-1:0] ADR_O,
    output logic [7:0]            DAT_O,
    input  logic [7:0]            DAT_I,
    output logic                  WE_O,
    output logic                  STB_O,
    output logic                  CYC_O,
    input  logic                  ACK_I,
    output logic                  busError
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(AUTO_INC);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_edges;

    frame_state_t          fstate_q, fstate_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            rx_q, rx_d;
    logic [7:0]            rx_byte;
    logic [7:0]            tx_q, tx_d;
    logic                  rnw_q, rnw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  miso_q, miso_d;
    logic                  err_q, err_d;
    logic                  req_wr_q, req_wr_d;
    logic                  req_rd_q, req_rd_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [7:0]            req_data_q, req_data_d;

    bus_state_t            bstate_q, bstate_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [7:0]            dat_q, dat_d;
    logic [7:0]            rbuf_q, rbuf_d;

    logic                  bus_drop, rd_ack, rd_ok;
    logic [7:0]            rd_data;

    spiSyncEdge #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk(CLK_I), .rst_n(RST_I), .din(sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    spiSyncEdge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(CLK_I), .rst_n(RST_I), .din(cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spiSyncEdge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(CLK_I), .rst_n(RST_I), .din(mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_edges = ^{sck_level, cs_rise, mosi_rise, mosi_fall};

    // a request arriving while a cycle is still open is lost
    assign bus_drop = (req_wr_q | req_rd_q) & (bstate_q != B_IDLE);
    // an ack in the boundary cycle itself still counts as in time
    assign rd_ack   = (bstate_q == B_READ) & ACK_I;
    assign rd_ok    = rd_ack | (bstate_q != B_READ);
    assign rd_data  = rd_ack ? DAT_I : rbuf_q;

    // frame FSM: cs framing, bit shifting and byte-boundary actions
    always_comb begin
        fstate_d   = fstate_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        err_d      = err_q;
        req_wr_d   = 1'b0;
        req_rd_d   = 1'b0;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        rx_byte    = {rx_q, mosi_level};
        if (bus_drop) err_d = 1'b1;
        if (cs_level) begin
            fstate_d = F_IDLE;
            miso_d   = 1'b0;
        end else begin
            if (cs_fall) begin
                fstate_d  = F_CMD;
                bit_cnt_d = 3'd0;
                tx_d      = TURNAROUND_FILL;
                err_d     = 1'b0;
                miso_d    = TURNAROUND_FILL[7];
            end
            if (fstate_d != F_IDLE) begin
                if (sck_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_d + 3'd1;
                    if (bit_cnt_d == 3'd0) begin
                        unique case (fstate_d)
                            F_CMD: begin
                                rnw_d    = rx_byte[CMD_RNW_BIT];
                                addr_d   = rx_byte[ADDR_WIDTH-1:0];
                                fstate_d = F_DATA;
                                if (rx_byte[CMD_RNW_BIT]) begin
                                    req_rd_d   = 1'b1;
                                    req_addr_d = rx_byte[ADDR_WIDTH-1:0];
                                end
                            end
                            F_DATA: begin
                                if (rnw_q) begin
                                    if (rd_ok) begin
                                        tx_d = rd_data;
                                    end else begin
                                        tx_d  = BUS_ERR_FILL;
                                        err_d = 1'b1;
                                    end
                                    addr_d     = addr_q + ADDR_STEP;
                                    req_rd_d   = 1'b1;
                                    req_addr_d = addr_d;
                                end else begin
                                    req_wr_d   = 1'b1;
                                    req_addr_d = addr_q;
                                    req_data_d = rx_byte;
                                    addr_d     = addr_q + ADDR_STEP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                if (sck_fall) miso_d = tx_d[3'd7 - bit_cnt_d];
            end
        end
    end

    // frame FSM state and registered frame-side outputs
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            fstate_q   <= F_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 7'd0;
            tx_q       <= TURNAROUND_FILL;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            miso_q     <= 1'b0;
            err_q      <= 1'b0;
            req_wr_q   <= 1'b0;
            req_rd_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= 8'd0;
        end else begin
            fstate_q   <= fstate_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            miso_q     <= miso_d;
            err_q      <= err_d;
            req_wr_q   <= req_wr_d;
            req_rd_q   <= req_rd_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
        end
    end

    // bus FSM: one Wishbone cycle per request, held until ACK
    always_comb begin
        bstate_d = bstate_q;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rbuf_d   = rbuf_q;
        unique case (bstate_q)
            B_IDLE: begin
                if (req_wr_q) begin
                    bstate_d = B_WRITE;
                    stb_d    = 1'b1;
                    we_d     = 1'b1;
                    adr_d    = req_addr_q;
                    dat_d    = req_data_q;
                end else if (req_rd_q) begin
                    bstate_d = B_READ;
                    stb_d    = 1'b1;
                    we_d     = 1'b0;
                    adr_d    = req_addr_q;
                end
            end
            B_WRITE, B_READ: begin
                if (ACK_I) begin
                    bstate_d = B_IDLE;
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    if (bstate_q == B_READ) rbuf_d = DAT_I;
                end
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    // bus FSM state and registered Wishbone outputs
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            bstate_q <= B_IDLE;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= 8'd0;
            rbuf_q   <= 8'd0;
        end else begin
            bstate_q <= bstate_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rbuf_q   <= rbuf_d;
        end
    end

    assign misoOe   = ~cs_level;
    assign miso     = miso_q & ~cs_level;
    assign STB_O    = stb_q;
    assign CYC_O    = stb_q;
    assign WE_O     = we_q;
    assign ADR_O    = adr_q;
    assign DAT_O    = dat_q;
    assign busError = err_q;

endmodule

// File: tb/tb_spi_slave_wishbone.sv
// tb_spi_slave_wishbone: SPI master driver, Wishbone slave
// model and reference memory for two bridge instances.
module tb_spi_slave_wishbone;

    localparam logic [7:0] FILL = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;
    int half = 4;
    int ack_delay = 0;
    int stb_cnt0 = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic       cs   [2];
    logic       miso [2];
    logic       oe   [2];
    logic       we   [2];
    logic       stb  [2];
    logic       cyc  [2];
    logic       ack  [2];
    logic       err  [2];
    logic [6:0] adr  [2];
    logic [7:0] dato [2];
    logic [7:0] dati [2];
    int         acnt [2];
    logic [7:0] mem [2][128];
    logic [7:0] ref_mem [128];
    logic [15:0] wr_q0 [$];
    logic [15:0] wr_q1 [$];
    logic [6:0]  rd_q0 [$];

    always #5 clk = ~clk;

    spi_slave_wishbone #(
        .ADDR_WIDTH(7), .AUTO_INC(1), .TURNAROUND_FILL(FILL)
    ) u_dut_inc (
        .CLK_I(clk), .RST_I(rst_n), .sck(sck), .cs(cs[0]),
        .mosi(mosi), .miso(miso[0]), .misoOe(oe[0]),
        .ADR_O(adr[0]), .DAT_O(dato[0]), .DAT_I(dati[0]),
        .WE_O(we[0]), .STB_O(stb[0]), .CYC_O(cyc[0]),
        .ACK_I(ack[0]), .busError(err[0])
    );

    spi_slave_wishbone #(
        .ADDR_WIDTH(7), .AUTO_INC(0), .TURNAROUND_FILL(FILL)
    ) u_dut_hold (
        .CLK_I(clk), .RST_I(rst_n), .sck(sck), .cs(cs[1]),
        .mosi(mosi), .miso(miso[1]), .misoOe(oe[1]),
        .ADR_O(adr[1]), .DAT_O(dato[1]), .DAT_I(dati[1]),
        .WE_O(we[1]), .STB_O(stb[1]), .CYC_O(cyc[1]),
        .ACK_I(ack[1]), .busError(err[1])
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 7 + 3) ^ 8'hA5);
    endfunction

    assign dati[0] = mem[0][adr[0]];
    assign dati[1] = mem[1][adr[1]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                ack[d]  <= 1'b0;
                acnt[d] <= 0;
            end
            for (int i = 0; i < 128; i++) begin
                mem[0][i] <= init_val(i);
                mem[1][i] <= init_val(i);
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (stb[d] && !ack[d]) begin
                    if (acnt[d] >= ack_delay) begin
                        ack[d]  <= 1'b1;
                        acnt[d] <= 0;
                    end else begin
                        acnt[d] <= acnt[d] + 1;
                    end
                end else begin
                    ack[d]  <= 1'b0;
                    acnt[d] <= 0;
                end
                if (stb[d] && ack[d] && we[d])
                    mem[d][adr[d]] <= dato[d];
            end
        end
    end

    always @(posedge clk) begin
        if (stb[0]) stb_cnt0 <= stb_cnt0 + 1;
        if (stb[0] && ack[0]) begin
            if (we[0]) wr_q0.push_back({1'b0, adr[0], dato[0]});
            else rd_q0.push_back(adr[0]);
        end
        if (stb[1] && ack[1] && we[1])
            wr_q1.push_back({1'b0, adr[1], dato[1]});
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input int sel, input logic [15:0] e,
                             input string tag);
        logic [15:0] got;
        got = 16'hDEAD;
        if (sel == 0 && wr_q0.size() > 0) got = wr_q0.pop_front();
        if (sel == 1 && wr_q1.size() > 0) got = wr_q1.pop_front();
        check(tag, 32'(got), 32'(e));
    endtask

    task automatic expect_rd(input logic [6:0] e, input string tag);
        logic [7:0] got;
        got = 8'hFF;
        if (rd_q0.size() > 0) got = {1'b0, rd_q0.pop_front()};
        check(tag, 32'(got), 32'(e));
    endtask

    task automatic cs_low(input int sel);
        cs[sel] = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic cs_high(input int sel);
        repeat (half) @(negedge clk);
        cs[sel] = 1'b1;
        repeat (2 * half + 6) @(negedge clk);
    endtask

    task automatic spi_bits(input int sel, input logic [7:0] tx,
                            input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b > 7 - nbits; b--) begin
            mosi = tx[b];
            repeat (half) @(negedge clk);
            sck = 1'b1;
            rx[b] = miso[sel];
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic wait_idle0();
        for (int i = 0; i < 400 && stb[0]; i++) @(negedge clk);
        check("bus_idle", 32'(stb[0]), 0);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx, tx, exp;
        logic rnw;
        int a, n, s0;
        logic [15:0] wexp [$];
        cs[0] = 1'b1;
        cs[1] = 1'b1;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(stb[0]), 0);
        check("rst_cyc", 32'(cyc[0]), 0);
        check("rst_we", 32'(we[0]), 0);
        check("rst_adr", 32'(adr[0]), 0);
        check("rst_dat", 32'(dato[0]), 0);
        check("rst_oe", 32'(oe[0]), 0);
        check("rst_miso", 32'(miso[0]), 0);
        check("rst_err", 32'(err[0]), 0);
        check("rst_oe1", 32'(oe[1]), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_oe", 32'(oe[0]), 0);
        check("post_rst_cyc1", 32'(cyc[1]), 0);

        // write frame 05 A1 B2
        cs_low(0);
        check("oe_on", 32'(oe[0]), 1);
        spi_bits(0, 8'h05, 8, rx);
        spi_bits(0, 8'hA1, 8, rx);
        spi_bits(0, 8'hB2, 8, rx);
        check("wr_err", 32'(err[0]), 0);
        cs_high(0);
        check("oe_off", 32'(oe[0]), 0);
        expect_wr(0, 16'h05A1, "wr_0");
        expect_wr(0, 16'h06B2, "wr_1");

        // load 3C/4D then read them back from 3
        cs_low(0);
        spi_bits(0, 8'h03, 8, rx);
        spi_bits(0, 8'h3C, 8, rx);
        spi_bits(0, 8'h4D, 8, rx);
        cs_high(0);
        expect_wr(0, 16'h033C, "wr_3");
        expect_wr(0, 16'h044D, "wr_4");
        rd_q0.delete();
        cs_low(0);
        spi_bits(0, 8'h83, 8, rx);
        check("rd_b0", 32'(rx), 32'(FILL));
        spi_bits(0, 8'($urandom), 8, rx);
        check("rd_b1", 32'(rx), 32'(FILL));
        spi_bits(0, 8'($urandom), 8, rx);
        check("rd_b2", 32'(rx), 32'h3C);
        spi_bits(0, 8'($urandom), 8, rx);
        check("rd_b3", 32'(rx), 32'h4D);
        check("rd_err", 32'(err[0]), 0);
        cs_high(0);
        expect_rd(7'd3, "rd_a0");
        expect_rd(7'd4, "rd_a1");
        expect_rd(7'd5, "rd_a2");

        // address hold instance
        cs_low(1);
        spi_bits(1, 8'h10, 8, rx);
        spi_bits(1, 8'h11, 8, rx);
        spi_bits(1, 8'h22, 8, rx);
        cs_high(1);
        expect_wr(1, 16'h1011, "hold_0");
        expect_wr(1, 16'h1022, "hold_1");
        check("hold_err", 32'(err[1]), 0);

        // slow ack: second data byte must carry the error fill
        half = 5;
        ack_delay = 100;
        cs_low(0);
        spi_bits(0, 8'h83, 8, rx);
        spi_bits(0, 8'h00, 8, rx);
        spi_bits(0, 8'h00, 8, rx);
        check("slow_b2", 32'(rx), 32'hEE);
        check("slow_err", 32'(err[0]), 1);
        ack_delay = 0;
        cs_high(0);
        wait_idle0();
        half = 4;
        rd_q0.delete();

        // cs raised mid data byte, then a normal write
        wr_q0.delete();
        cs_low(0);
        check("err_clr", 32'(err[0]), 0);
        spi_bits(0, 8'h01, 8, rx);
        s0 = stb_cnt0;
        spi_bits(0, 8'h55, 4, rx);
        cs_high(0);
        check("abort_stb", 32'(stb_cnt0 - s0), 0);
        check("abort_wr", 32'(wr_q0.size()), 0);
        cs_low(0);
        spi_bits(0, 8'h01, 8, rx);
        spi_bits(0, 8'h55, 8, rx);
        cs_high(0);
        expect_wr(0, 16'h0155, "after_abort");

        // async reset while a read cycle is open
        ack_delay = 50;
        cs_low(0);
        spi_bits(0, 8'h83, 8, rx);
        for (int i = 0; i < 20 && !stb[0]; i++) @(negedge clk);
        check("pre_rst_stb", 32'(stb[0]), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_stb", 32'(stb[0]), 0);
        check("arst_cyc", 32'(cyc[0]), 0);
        check("arst_oe", 32'(oe[0]), 0);
        cs[0] = 1'b1;
        ack_delay = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        wr_q0.delete();
        rd_q0.delete();

        // random frames against the reference memory
        for (int f = 0; f < 24; f++) begin
            half = $urandom_range(6, 4);
            ack_delay = $urandom_range(3, 0);
            a = $urandom_range(127, 0);
            rnw = 1'($urandom_range(1, 0));
            n = $urandom_range(4, 1);
            wexp.delete();
            cs_low(0);
            spi_bits(0, {rnw, 7'(a)}, 8, rx);
            check("rnd_cmd", 32'(rx), 32'(FILL));
            for (int k = 1; k <= n; k++) begin
                tx = 8'($urandom);
                spi_bits(0, tx, 8, rx);
                if (rnw) begin
                    exp = (k == 1) ? FILL : ref_mem[(a + k - 2) & 127];
                    check("rnd_rd", 32'(rx), 32'(exp));
                end else begin
                    ref_mem[(a + k - 1) & 127] = tx;
                    wexp.push_back({1'b0, 7'((a + k - 1) & 127), tx});
                end
            end
            check("rnd_err", 32'(err[0]), 0);
            cs_high(0);
            check("rnd_wr_cnt", 32'(wr_q0.size()), 32'(wexp.size()));
            while (wexp.size() > 0) expect_wr(0, wexp.pop_front(), "rnd_wr");
            wr_q0.delete();
            rd_q0.delete();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
